// File: rtl/execute_stage_pkg.sv
// Shared constants for the execute stage: datapath width, ALU opcodes,
// forwarding selects and the multiplier FSM state type.
package execute_stage_pkg;

    localparam int WORD_SIZE = 32;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLT = 4'd5;
    localparam logic [3:0] ALU_SLL = 4'd6;
    localparam logic [3:0] ALU_SRL = 4'd7;
    localparam logic [3:0] ALU_SRA = 4'd8;
    localparam logic [3:0] ALU_MUL = 4'd9;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/execute_stage_if.sv
// Execute-stage bundle: decode-side E inputs and the EX/MEM outputs.
// The pipeline drives through master; the execute stage uses slave.
interface execute_stage_if #(
    parameter int WORD_SIZE = execute_stage_pkg::WORD_SIZE
);
    logic [WORD_SIZE-1:0] RD1E;
    logic [WORD_SIZE-1:0] RD2E;
    logic [WORD_SIZE-1:0] PCE;
    logic [WORD_SIZE-1:0] ImmExtE;
    logic [WORD_SIZE-1:0] PCPlus4E;
    logic [4:0]           RdE;
    logic [WORD_SIZE-1:0] ResultW;
    logic [1:0]           ForwardAE;
    logic [1:0]           ForwardBE;
    logic                 RegWriteE;
    logic                 MemWriteE;
    logic                 JumpE;
    logic                 BranchE;
    logic                 ALUSrcE;
    logic [1:0]           ResultSrcE;
    logic [3:0]           ALUControlE;

    logic [WORD_SIZE-1:0] ALUResultM;
    logic [WORD_SIZE-1:0] WriteDataM;
    logic [WORD_SIZE-1:0] PCPlus4M;
    logic [4:0]           RdM;
    logic                 RegWriteM;
    logic                 MemWriteM;
    logic [1:0]           ResultSrcM;
    logic [WORD_SIZE-1:0] PCTargetE;
    logic                 PCSrcE;
    logic                 StallE;

    modport master (
        output RD1E, RD2E, PCE, ImmExtE, PCPlus4E, RdE, ResultW,
               ForwardAE, ForwardBE, RegWriteE, MemWriteE, JumpE, BranchE,
               ALUSrcE, ResultSrcE, ALUControlE,
        input  ALUResultM, WriteDataM, PCPlus4M, RdM, RegWriteM, MemWriteM,
               ResultSrcM, PCTargetE, PCSrcE, StallE
    );

    modport slave (
        input  RD1E, RD2E, PCE, ImmExtE, PCPlus4E, RdE, ResultW,
               ForwardAE, ForwardBE, RegWriteE, MemWriteE, JumpE, BranchE,
               ALUSrcE, ResultSrcE, ALUControlE,
        output ALUResultM, WriteDataM, PCPlus4M, RdM, RegWriteM, MemWriteM,
               ResultSrcM, PCTargetE, PCSrcE, StallE
    );

endinterface

// File: rtl/execute_stage_alu.sv
// Single-cycle combinational ALU. MUL is handled by the sequential multiplier
// in the execute stage, so here it falls through to zero like unused codes.
module alu
    import execute_stage_pkg::*;
#(
    parameter int WORD_SIZE = execute_stage_pkg::WORD_SIZE
) (
    input  logic [WORD_SIZE-1:0] src_a,
    input  logic [WORD_SIZE-1:0] src_b,
    input  logic [3:0]           alu_control,
    output logic [WORD_SIZE-1:0] result,
    output logic                 zero
);

    logic [4:0] shamt_s;

    // Operation select; shift amount comes from the low five bits of src_b
    always_comb begin
        result  = '0;
        shamt_s = src_b[4:0];
        case (alu_control)
            ALU_ADD: result = src_a + src_b;
            ALU_SUB: result = src_a - src_b;
            ALU_AND: result = src_a & src_b;
            ALU_OR:  result = src_a | src_b;
            ALU_XOR: result = src_a ^ src_b;
            ALU_SLT: result = {{(WORD_SIZE-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            ALU_SLL: result = src_a << shamt_s;
            ALU_SRL: result = src_a >> shamt_s;
            ALU_SRA: result = $signed(src_a) >>> shamt_s;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU, branch resolution, a shift-add
// multiplier that stalls upstream, and the EX/MEM pipeline register.
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int WORD_SIZE = execute_stage_pkg::WORD_SIZE
) (
    input  logic             clk,
    input  logic             rst,
    execute_stage_if.slave   ex
);

    localparam int              CNT_W    = $clog2(WORD_SIZE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_SIZE - 1);

    logic [WORD_SIZE-1:0] src_a_s;
    logic [WORD_SIZE-1:0] write_data_s;
    logic [WORD_SIZE-1:0] src_b_s;
    logic [WORD_SIZE-1:0] alu_result_s;
    logic                 zero_s;
    logic                 mul_req_s;
    logic                 stall_s;

    mul_state_e           state_q,  state_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic [WORD_SIZE-1:0] mcand_q,  mcand_d;
    logic [WORD_SIZE-1:0] mplier_q, mplier_d;
    logic [WORD_SIZE-1:0] acc_q,    acc_d;

    logic [WORD_SIZE-1:0] alu_result_m_q, alu_result_m_d;
    logic [WORD_SIZE-1:0] write_data_m_q, write_data_m_d;
    logic [WORD_SIZE-1:0] pc_plus4_m_q,   pc_plus4_m_d;
    logic [4:0]           rd_m_q,         rd_m_d;
    logic                 reg_write_m_q,  reg_write_m_d;
    logic                 mem_write_m_q,  mem_write_m_d;
    logic [1:0]           result_src_m_q, result_src_m_d;

    // Forwarding muxes; the unused 11 encoding falls back to the register value
    always_comb begin
        src_a_s      = ex.RD1E;
        write_data_s = ex.RD2E;
        case (ex.ForwardAE)
            FWD_WB:  src_a_s = ex.ResultW;
            FWD_MEM: src_a_s = alu_result_m_q;
            default: src_a_s = ex.RD1E;
        endcase
        case (ex.ForwardBE)
            FWD_WB:  write_data_s = ex.ResultW;
            FWD_MEM: write_data_s = alu_result_m_q;
            default: write_data_s = ex.RD2E;
        endcase
    end

    assign src_b_s = ex.ALUSrcE ? ex.ImmExtE : write_data_s;

    alu #(.WORD_SIZE(WORD_SIZE)) u_alu (
        .src_a       (src_a_s),
        .src_b       (src_b_s),
        .alu_control (ex.ALUControlE),
        .result      (alu_result_s),
        .zero        (zero_s)
    );

    assign mul_req_s = (ex.ALUControlE == ALU_MUL);

    // Multiplier FSM: latch operands, run one shift-add step per cycle, then
    // spend one cycle in DONE while the product is written into EX/MEM
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        stall_s  = 1'b0;
        case (state_q)
            MUL_IDLE: begin
                if (mul_req_s) begin
                    stall_s  = 1'b1;
                    mcand_d  = src_a_s;
                    mplier_d = src_b_s;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = MUL_BUSY;
                end else begin
                    state_d  = MUL_IDLE;
                end
            end
            MUL_BUSY: begin
                stall_s = 1'b1;
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end else begin
                    acc_d = acc_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                if (cnt_q == CNT_LAST) begin
                    state_d = MUL_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            MUL_DONE: state_d = MUL_IDLE;
            default:  state_d = MUL_IDLE;
        endcase
    end

    // Multiplier state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MUL_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

    // EX/MEM next value: bubble while stalled, product in DONE, ALU otherwise
    always_comb begin
        alu_result_m_d = '0;
        write_data_m_d = '0;
        pc_plus4_m_d   = '0;
        rd_m_d         = 5'd0;
        reg_write_m_d  = 1'b0;
        mem_write_m_d  = 1'b0;
        result_src_m_d = 2'b00;
        if (stall_s) begin
            alu_result_m_d = '0;
        end else begin
            if (state_q == MUL_DONE) begin
                alu_result_m_d = acc_q;
            end else begin
                alu_result_m_d = alu_result_s;
            end
            write_data_m_d = write_data_s;
            pc_plus4_m_d   = ex.PCPlus4E;
            rd_m_d         = ex.RdE;
            reg_write_m_d  = ex.RegWriteE;
            mem_write_m_d  = ex.MemWriteE;
            result_src_m_d = ex.ResultSrcE;
        end
    end

    // EX/MEM pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_result_m_q <= '0;
            write_data_m_q <= '0;
            pc_plus4_m_q   <= '0;
            rd_m_q         <= 5'd0;
            reg_write_m_q  <= 1'b0;
            mem_write_m_q  <= 1'b0;
            result_src_m_q <= 2'b00;
        end else begin
            alu_result_m_q <= alu_result_m_d;
            write_data_m_q <= write_data_m_d;
            pc_plus4_m_q   <= pc_plus4_m_d;
            rd_m_q         <= rd_m_d;
            reg_write_m_q  <= reg_write_m_d;
            mem_write_m_q  <= mem_write_m_d;
            result_src_m_q <= result_src_m_d;
        end
    end

    assign ex.ALUResultM = alu_result_m_q;
    assign ex.WriteDataM = write_data_m_q;
    assign ex.PCPlus4M   = pc_plus4_m_q;
    assign ex.RdM        = rd_m_q;
    assign ex.RegWriteM  = reg_write_m_q;
    assign ex.MemWriteM  = mem_write_m_q;
    assign ex.ResultSrcM = result_src_m_q;
    assign ex.StallE     = stall_s;
    assign ex.PCTargetE  = ex.PCE + ex.ImmExtE;
    // A multiply in flight (or being accepted) can never redirect fetch
    assign ex.PCSrcE     = (state_q == MUL_IDLE) & ~mul_req_s &
                           (ex.JumpE | (ex.BranchE & zero_s));

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage: ALU ops, forwarding,
// branch resolution, multiplier stall/bubble timing and mid-multiply reset.
module tb_execute_stage;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    execute_stage_if #(.WORD_SIZE(32)) ex_if ();

    execute_stage #(.WORD_SIZE(32)) dut (
        .clk (clk),
        .rst (rst),
        .ex  (ex_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ex_if.RD1E        = 32'h0;
        ex_if.RD2E        = 32'h0;
        ex_if.PCE         = 32'h0;
        ex_if.ImmExtE     = 32'h0;
        ex_if.PCPlus4E    = 32'h0;
        ex_if.RdE         = 5'd0;
        ex_if.ResultW     = 32'h0;
        ex_if.ForwardAE   = 2'b00;
        ex_if.ForwardBE   = 2'b00;
        ex_if.RegWriteE   = 1'b0;
        ex_if.MemWriteE   = 1'b0;
        ex_if.JumpE       = 1'b0;
        ex_if.BranchE     = 1'b0;
        ex_if.ALUSrcE     = 1'b0;
        ex_if.ResultSrcE  = 2'b00;
        ex_if.ALUControlE = 4'd0;
    endtask

    // Present a MUL (operand A via the writeback forward path), then follow it
    // to completion: 33 stall cycles with bubbles, product on the 34th edge.
    task automatic mul_run(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input string tag);
        int stall_cnt;
        int bubble_err;
        int pc_err;
        stall_cnt  = 0;
        bubble_err = 0;
        pc_err     = 0;
        clear_inputs();
        ex_if.ForwardAE   = 2'b01;
        ex_if.ResultW     = a;
        ex_if.RD1E        = 32'h1234;
        ex_if.RD2E        = b;
        ex_if.ALUControlE = 4'd9;
        ex_if.RegWriteE   = 1'b1;
        ex_if.BranchE     = 1'b1;
        ex_if.RdE         = 5'd5;
        #1;
        check({tag, "_stall_first"}, {31'd0, ex_if.StallE}, 32'd1);
        for (int i = 0; i < 40; i++) begin
            if (!ex_if.StallE) break;
            stall_cnt++;
            tick();
            if (stall_cnt == 5) ex_if.ResultW = 32'h0;
            if ((ex_if.ALUResultM != 32'h0) || ex_if.RegWriteM || ex_if.MemWriteM ||
                (ex_if.RdM != 5'd0) || (ex_if.WriteDataM != 32'h0))
                bubble_err++;
            if (ex_if.PCSrcE) pc_err++;
        end
        check({tag, "_stall_cycles"}, stall_cnt, 32'd33);
        check({tag, "_bubbles"}, bubble_err, 32'd0);
        check({tag, "_no_branch"}, pc_err, 32'd0);
        tick();
        check({tag, "_product"}, ex_if.ALUResultM, exp);
        check({tag, "_regwrite"}, {31'd0, ex_if.RegWriteM}, 32'd1);
        check({tag, "_rd"}, {27'd0, ex_if.RdM}, 32'd5);
    endtask

    logic [31:0] op_a   [12] = '{32'hF0F0F0F0, 32'hF0F00000, 32'hFFFF0000, 32'hFFFFFFFF,
                                 32'h00000001, 32'h00000001, 32'h80000000, 32'h80000000,
                                 32'h00000000, 32'hFFFFFFFF, 32'h00000005, 32'h00000005};
    logic [31:0] op_b   [12] = '{32'hFF00FF00, 32'h0000000F, 32'h0F0F0F0F, 32'h00000001,
                                 32'hFFFFFFFF, 32'h00000021, 32'h00000004, 32'h00000004,
                                 32'h00000001, 32'h00000002, 32'h00000006, 32'h00000006};
    logic [3:0]  op_c   [12] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd5, 4'd6, 4'd7, 4'd8,
                                 4'd1, 4'd0, 4'd10, 4'd15};
    logic [31:0] op_exp [12] = '{32'hF000F000, 32'hF0F0000F, 32'hF0F00F0F, 32'h00000001,
                                 32'h00000000, 32'h00000002, 32'h08000000, 32'hF8000000,
                                 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000000};

    initial begin
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        check("rst_aluresult", ex_if.ALUResultM, 32'h0);
        check("rst_regwrite", {31'd0, ex_if.RegWriteM}, 32'd0);
        check("rst_rd", {27'd0, ex_if.RdM}, 32'd0);
        check("rst_stall", {31'd0, ex_if.StallE}, 32'd0);
        rst = 1'b0;

        // ADD with immediate, plus pass-through fields
        ex_if.RD1E = 32'd5;  ex_if.ImmExtE = 32'd7; ex_if.ALUSrcE = 1'b1;
        ex_if.RdE = 5'd3;    ex_if.RegWriteE = 1'b1; ex_if.RD2E = 32'hAB;
        ex_if.PCPlus4E = 32'h104; ex_if.ResultSrcE = 2'b01; ex_if.MemWriteE = 1'b1;
        tick();
        check("add_result", ex_if.ALUResultM, 32'd12);
        check("add_rd", {27'd0, ex_if.RdM}, 32'd3);
        check("add_regwrite", {31'd0, ex_if.RegWriteM}, 32'd1);
        check("add_writedata", ex_if.WriteDataM, 32'hAB);
        check("add_pcplus4", ex_if.PCPlus4M, 32'h104);
        check("add_resultsrc", {30'd0, ex_if.ResultSrcM}, 32'd1);
        check("add_memwrite", {31'd0, ex_if.MemWriteM}, 32'd1);

        // Forwarding paths
        clear_inputs();
        ex_if.ForwardAE = 2'b01; ex_if.ResultW = 32'd100; ex_if.RD1E = 32'd7;
        ex_if.RD2E = 32'd1; ex_if.ALUControlE = 4'd1; ex_if.RegWriteE = 1'b1;
        tick();
        check("fwd_a_wb", ex_if.ALUResultM, 32'd99);
        ex_if.ForwardAE = 2'b10;
        tick();
        check("fwd_a_mem", ex_if.ALUResultM, 32'd98);
        ex_if.ForwardAE = 2'b00; ex_if.ForwardBE = 2'b10; ex_if.RD1E = 32'd200;
        tick();
        check("fwd_b_mem", ex_if.ALUResultM, 32'd102);
        ex_if.ForwardAE = 2'b11; ex_if.RD1E = 32'd50; ex_if.ForwardBE = 2'b01;
        ex_if.ResultW = 32'd8; ex_if.ALUControlE = 4'd0;
        tick();
        check("fwd_a_11", ex_if.ALUResultM, 32'd58);
        check("fwd_b_wb_wdata", ex_if.WriteDataM, 32'd8);

        // ALU operation table
        for (int i = 0; i < 12; i++) begin
            clear_inputs();
            ex_if.RD1E = op_a[i]; ex_if.RD2E = op_b[i]; ex_if.ALUControlE = op_c[i];
            tick();
            check($sformatf("alu_op%0d_%0d", op_c[i], i), ex_if.ALUResultM, op_exp[i]);
        end

        // Branch resolution and target
        clear_inputs();
        ex_if.BranchE = 1'b1; ex_if.ALUControlE = 4'd1;
        ex_if.RD1E = 32'd9; ex_if.RD2E = 32'd9; ex_if.PCE = 32'h40; ex_if.ImmExtE = 32'h10;
        #1;
        check("br_taken", {31'd0, ex_if.PCSrcE}, 32'd1);
        check("br_target", ex_if.PCTargetE, 32'h50);
        ex_if.RD2E = 32'd8;
        #1;
        check("br_not_taken", {31'd0, ex_if.PCSrcE}, 32'd0);
        ex_if.BranchE = 1'b0; ex_if.JumpE = 1'b1;
        #1;
        check("jump", {31'd0, ex_if.PCSrcE}, 32'd1);
        ex_if.PCE = 32'hFFFFFFF0; ex_if.ImmExtE = 32'h20;
        #1;
        check("target_wrap", ex_if.PCTargetE, 32'h10);
        clear_inputs();
        tick();

        // Multiplies, including back-to-back
        mul_run(32'hFFFFFFFF, 32'd3, 32'hFFFFFFFD, "mul_neg");
        mul_run(32'd6, 32'd7, 32'd42, "mul_b2b_a");
        mul_run(32'h00010000, 32'h00010000, 32'h0, "mul_b2b_b");

        // Reset during BUSY aborts the multiply
        clear_inputs();
        ex_if.RD1E = 32'hFFFFFFFF; ex_if.RD2E = 32'd3; ex_if.ALUControlE = 4'd9;
        ex_if.RegWriteE = 1'b1; ex_if.RdE = 5'd5;
        repeat (11) tick();
        check("mid_mul_stall", {31'd0, ex_if.StallE}, 32'd1);
        rst = 1'b1;
        ex_if.ALUControlE = 4'd0; ex_if.RD1E = 32'd2; ex_if.RdE = 5'd7;
        tick();
        check("rstmul_aluresult", ex_if.ALUResultM, 32'h0);
        check("rstmul_regwrite", {31'd0, ex_if.RegWriteM}, 32'd0);
        check("rstmul_rd", {27'd0, ex_if.RdM}, 32'd0);
        check("rstmul_writedata", ex_if.WriteDataM, 32'h0);
        check("rstmul_stall", {31'd0, ex_if.StallE}, 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_add", ex_if.ALUResultM, 32'd5);
        check("post_rst_rd", {27'd0, ex_if.RdM}, 32'd7);
        check("post_rst_regwrite", {31'd0, ex_if.RegWriteM}, 32'd1);
        mul_run(32'd3, 32'd5, 32'd15, "mul_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 Parameter: WORD_SIZE, default 32 from shared constants, datapath width.
REQ-002 Ports; one clock; reset is synchronous and active-high:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- RD1E, RD2E  in  WORD_SIZE  register-file operands
- PCE, ImmExtE, PCPlus4E  in  WORD_SIZE  PC, extended immediate, PC+4
- RdE  in  5  destination register
- ResultW  in  WORD_SIZE  writeback forwarding value
- ForwardAE, ForwardBE  in  2  00 register, 01 ResultW, 10 ALUResultM
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  in  1  decode controls
- ResultSrcE  in  2  result select, passed through
- ALUControlE  in  4  ALU operation
- ALUResultM, WriteDataM, PCPlus4M  out  WORD_SIZE  EX/MEM register contents
- RdM  out  5  registered destination
- RegWriteM, MemWriteM  out  1  registered controls
- ResultSrcM  out  2  registered result select
- PCTargetE  out  WORD_SIZE  PCE + ImmExtE, combinational
- PCSrcE  out  1  redirect fetch, combinational
- StallE  out  1  multiplier busy; upstream holds all E inputs

Function
REQ-003 SrcAE = mux(ForwardAE: RD1E, ResultW, ALUResultM); 11 selects RD1E.
REQ-004 WriteDataE = same mux on ForwardBE over RD2E; SrcBE = ALUSrcE ? ImmExtE : WriteDataE.
REQ-005 ALU codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 SLL, 7 SRL, 8 SRA, 9 MUL; others yield 0; shifts use SrcBE[4:0].
REQ-006 ADD/SUB wrap modulo 2^WORD_SIZE; Zero = (ALU result == 0).
REQ-007 PCSrcE = JumpE | (BranchE & Zero); PCTargetE wraps modulo 2^WORD_SIZE.
REQ-008 Non-MUL ops: one-cycle latency; EX/MEM register loads ALU result, WriteDataE, PCPlus4E, RdE, controls every edge.
REQ-009 MUL FSM states: IDLE, BUSY, DONE.
REQ-010 IDLE & ALUControlE==MUL: StallE=1 combinationally; edge latches SrcAE, SrcBE, clears counter, -> BUSY.
REQ-011 BUSY: one shift-add step per cycle, StallE=1; after step 32 (counter 31) -> DONE.
REQ-012 DONE: StallE=0; EX/MEM loads low WORD_SIZE product bits plus held E controls; -> IDLE.
REQ-013 MUL total: 34 cycles in E, StallE high exactly 33 consecutive cycles.
REQ-014 While StallE=1, EX/MEM loads a bubble: RegWriteM=0, MemWriteM=0, other fields 0.
REQ-015 Forwarded values changing during BUSY do not affect the product (operands latched).
REQ-016 Back-to-back MULs: DONE->IDLE, next MUL restarts at REQ-010, no dropped cycle of output.
REQ-017 PCSrcE is 0 during BUSY/DONE (MUL never branches).

Reset
REQ-018 rst at clock edge: all M outputs 0, FSM IDLE, counter 0, operand latches 0.
REQ-019 rst mid-MUL aborts it; no partial product ever reaches ALUResultM.
REQ-020 Combinational outputs (PCTargetE, PCSrcE, StallE) follow inputs/state; StallE=0 in reset cycle after edge unless a MUL is presented.

Structure
REQ-021 WORD_SIZE and the ALU opcode constants live in shared constants.v.
REQ-022 One sub-module, alu (combinational, REQ-005/006 except MUL); FSM, multiplier, muxes and EX/MEM register in execute_stage.

Verification
REQ-023 ADD RD1E=5, ImmExtE=7, ALUSrcE=1, RdE=3, RegWriteE=1 -> next edge ALUResultM=12, RdM=3, RegWriteM=1.
REQ-024 ForwardAE=01, ResultW=100, RD2E=1, SUB -> ALUResultM=99; ForwardAE=10 uses previous ALUResultM.
REQ-025 BranchE=1, SUB, RD1E=RD2E=9, PCE=0x40, ImmExtE=0x10 -> PCSrcE=1, PCTargetE=0x50; RD2E=8 -> PCSrcE=0.
REQ-026 MUL 0xFFFFFFFF*3 -> StallE high 33 cycles, bubbles in M, then ALUResultM=0xFFFFFFFD, RegWriteM=1.
REQ-027 rst asserted at BUSY cycle 10 -> all M outputs 0, StallE=0 next cycle, new ADD completes normally.
REQ-028 Two back-to-back MULs 6*7, 0x10000*0x10000 -> ALUResultM=42 then 0, each after 34 cycles.
